// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed 4-digit common-anode 7-segment driver for packed BCD mm:ss
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] pre;
  logic         tick;
  logic [1:0]   idx, nidx;
  logic [15:0]  shadow;
  logic         dp_state;
  logic [3:0]   nib;
  logic [3:0]   lz;
  logic         blank;
  logic [6:0]   glyph;
  assign tick = pre == W'(SCAN_DIV - 1);
  // Next digit, its nibble from the pre-edge shadow, and whether it falls in the leading-zero run
  always_comb begin
    nidx  = idx + 2'd1;
    nib   = shadow[4*nidx +: 4];
    lz[3] = shadow[15:12] == 4'h0;
    lz[2] = lz[3] && shadow[11:8] == 4'h0;
    lz[1] = lz[2] && shadow[7:4] == 4'h0;
    lz[0] = 1'b0;
    blank = blank_lz && lz[nidx];
  end
  // Segment glyph for the selected nibble; non-decimal nibbles show a dash
  always_comb begin
    case (nib)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end
  // Prescaler, shadow capture, dot toggle, and registered outputs updated only on scan ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      idx      <= 2'd0;
      shadow   <= 16'h0000;
      dp_state <= 1'b1;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
      dp       <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (load) shadow <= bcd_in;
      if (blink) dp_state <= ~dp_state;
      if (tick) begin
        idx <= nidx;
        an  <= ~(4'b0001 << nidx);
        seg <= blank ? 7'b1111111 : glyph;
        dp  <= ~(nidx == 2'd2 && dp_state);
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed and random stimulus checked against a frame-level display model
module tb_bcd_scan_display;
  localparam int SD = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  int          tests = 0;
  int          fails = 0;
  int          n, k;
  logic [15:0] msh;
  logic        mdp;
  logic [3:0]  ean;
  logic [6:0]  eseg;
  logic        edp;
  logic [6:0]  segtab [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .blank_lz(blank_lz), .blink(blink), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic l, input logic [15:0] b, input logic z, input logic bk);
    int d;
    rst = r; load = l; bcd_in = b; blank_lz = z; blink = bk;
    @(posedge clk);
    if (r) begin
      n = 0; k = 0; msh = 16'h0000; mdp = 1'b1;
      ean = 4'b1110; eseg = 7'b1000000; edp = 1'b1;
    end else begin
      if (n % SD == SD - 1) begin
        k = (k + 1) % 4;
        d = (msh >> (4 * k)) & 15;
        ean = 4'b1111 ^ (4'b0001 << k);
        eseg = (z && k > 0 && (msh >> (4 * k)) == 0) ? 7'b1111111 : segtab[d];
        edp = !(k == 2 && mdp);
      end
      if (l) msh = b;
      if (bk) mdp = !mdp;
      n++;
    end
    #1;
    tests++;
    assert (an === ean) else begin fails++; $error("FAIL an n=%0d got=%b exp=%b", n, an, ean); end
    tests++;
    assert (seg === eseg) else begin fails++; $error("FAIL seg n=%0d got=%b exp=%b", n, seg, eseg); end
    tests++;
    assert (dp === edp) else begin fails++; $error("FAIL dp n=%0d got=%b exp=%b", n, dp, edp); end
  endtask

  task automatic idle(input int cnt, input logic z);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 16'h0000, z, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(20, 1'b0);
    step(1'b0, 1'b1, 16'h1259, 1'b0, 1'b0);
    idle(20, 1'b0);
    step(1'b0, 1'b1, 16'h0007, 1'b1, 1'b0);
    idle(20, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(20, 1'b1);
    step(1'b0, 1'b1, 16'h0A05, 1'b1, 1'b0);
    idle(20, 1'b1);
    idle(16, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(16, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(16, 1'b0);
    for (int i = 0; i < 16 && !(n % SD == SD - 1 && (k + 1) % 4 == 2); i++) idle(1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(20, 1'b0);
    for (int i = 0; i < 8 && n % SD != SD - 1; i++) idle(1, 1'b0);
    step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
    idle(10, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(20, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] b;
      b = 16'($urandom) & (16'hffff >> (4 * $urandom_range(0, 3)));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, b,
           1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the cascaded BCD time counters. Takes a 4-digit packed BCD value (minutes:seconds, two 8-bit mod-60 count bytes) and drives a time-multiplexed, common-anode 4-digit 7-segment display.
- Contains:
  - a refresh prescaler,
  - a digit scan counter,
  - a tear-free shadow capture register,
  - leading-zero blanking,
  - invalid-BCD indication,
  - a blinking separator dot.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is held; legal range ≥2. The prescaler width is derived as ceil(log2(SCAN_DIV)).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- bcd_in  input  16  packed BCD: [15:12] digit3 (min tens), [11:8] digit2, [7:4] digit1, [3:0] digit0 (sec units)
- load  input  1  capture strobe: bcd_in is copied into the shadow register at this edge
- blank_lz  input  1  1 = leading-zero blanking enabled
- blink  input  1  one-cycle pulse; toggles the separator dot state
- an  output  4  digit anodes, active low, one-hot-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low

Behaviour:
- Reset (rst=1 at posedge) sets:
  - prescaler=0, digit_idx=0, shadow=16'h0000, dp_state=1
  - an=4'b1110, seg=7'b1000000 ("0"), dp=1
- rst has priority over all other inputs. Reset mid-scan discards the scan position and the shadow value.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 (internal) in the cycle where prescaler==SCAN_DIV-1.
- Digit scan:
  - At an edge with tick=1, digit_idx advances 0→1→2→3→0.
  - an, seg and dp are registered at that same edge for the new index.
  - an is low only on the bit of the new index.
  - Each digit is held exactly SCAN_DIV cycles. The first advance occurs SCAN_DIV edges after reset is released.
  - No outputs change on non-tick edges.
- Shadow capture:
  - shadow<=bcd_in at any edge with load=1; otherwise shadow holds.
  - Output encoding always uses the shadow value as it stood before the current edge. A load coinciding with a tick is therefore displayed from the next tick onward.
- Segment encoding (digit value d, from shadow):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles A–F are invalid BCD and display "-" = 0111111. Invalid digits are never blanked.
- Leading-zero blanking (blank_lz=1):
  - Digit k∈{3,2,1} is blanked (seg=1111111) iff digits k..3 of shadow are all 4'h0.
  - Digit 0 is never blanked.
  - When a digit is blanked, its anode is still driven active.
  - blank_lz is sampled at the tick edge.
- Separator dot:
  - dp_state toggles at every edge with blink=1, including non-tick edges.
  - dp=0 only when the registered digit index is 2 and dp_state (value before the edge) is 1; otherwise dp=1.
  - blink and tick may coincide: the dot uses the pre-toggle dp_state.
- No combinational path from any input to any output.

Test Plan:
- SCAN_DIV=4, reset, no load → an=1110 with seg=1000000 for 4 cycles, then an cycles 1101→1011→0111→1110, each held 4 cycles; all digits show "0" (blank_lz=0).
- load=1 with bcd_in=16'h1259 one cycle → from the next tick: digit0 seg=0010000 ("9"), digit1 0010010 ("5"), digit2 0100100 ("2"), digit3 1111001 ("1").
- blank_lz=1, shadow=16'h0007 → digits 3, 2, 1 seg=1111111 with anodes still active; digit0 seg=1111000. With shadow=16'h0000: only digit0 lit, showing "0".
- shadow=16'h0A05, blank_lz=1 → digit3 blanked; digit2 seg=0111111 ("-"); digit1 seg=1000000 (not blanked, a higher digit is nonzero); digit0 seg=0010010.
- blink pulses → dp=0 during digit2 when dp_state=1; after one blink, dp=1 for the whole next scan frame; after a second blink, dp=0 on digit2 again. blink coincident with the digit2 tick → dot uses the old state.
- load coincident with a tick, then rst asserted mid-frame → new value appears only from the following tick; after rst, an=1110, seg=1000000, dp=1, shadow cleared.
